store_write_buffer: RTL and testbench

Four-entry posted-store buffer between the Memory-Access stage and the data-memory write port. Stores leaving the MEM stage are queued in order and drained to memory by a request/acknowledge engine, so the pipeline does not wait on slow writes. Loads in the MEM stage search the buffer and take forwarded data from the youngest matching entry; misses read memory through its separate read port. The buffer asserts a stall toward the hazard logic when it is full and a new store arrives.

---
 rtl/store_buf_pkg.sv | 12 +
 rtl/store_buffer_match.sv | 34 +++
 rtl/store_write_buffer.sv | 149 ++++++++++++++
 tb/tb_store_write_buffer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buf_pkg.sv
// Shared types and defaults for the posted-store write buffer.
package store_buf_pkg;

    localparam int DEF_DEPTH = 4;
    localparam int PTR_W     = $clog2(DEF_DEPTH);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } drain_state_t;

endpackage

// File: rtl/store_buffer_match.sv
// Youngest-first address search over the occupied buffer slots.
module store_buffer_match
    import store_buf_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = 32,
    parameter int PW    = PTR_W
) (
    input  logic [DEPTH-1:0] valid,
    input  logic [AW-1:0]    addrs [DEPTH],
    input  logic [PW-1:0]    wr_ptr,
    input  logic [AW-1:0]    query,
    output logic             hit,
    output logic [PW-1:0]    idx
);

    logic [PW-1:0] slot;

    // Walk from the oldest position up to the slot just behind wr_ptr, so the
    // last match found (the youngest) wins.
    always_comb begin
        hit  = 1'b0;
        idx  = '0;
        slot = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            slot = wr_ptr - PW'(k);
            if (valid[slot] && (addrs[slot] == query)) begin
                hit = 1'b1;
                idx = slot;
            end
        end
    end

endmodule

// File: rtl/store_write_buffer.sv
// Posted-store buffer: in-order FIFO of MEM-stage stores, drained to memory by a
// req/ack engine, with youngest-match load forwarding.
module store_write_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                       CLOCK,
    input  logic                       RESET,
    input  logic                       St_Valid_M,
    input  logic [AW-1:0]              St_Addr_M,
    input  logic [DW-1:0]              St_Data_M,
    input  logic                       Ld_Valid_M,
    input  logic [AW-1:0]              Ld_Addr_M,
    output logic                       Ld_Hit_M,
    output logic [DW-1:0]              Ld_Data_M,
    output logic                       Stall_M,
    output logic                       Mem_Req,
    output logic [AW-1:0]              Mem_Addr,
    output logic [DW-1:0]              Mem_Data,
    input  logic                       Mem_Ack,
    output logic                       Empty,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] addr_q [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] nxt_ptr;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    drain_state_t  state;

    logic          full;
    logic          push;
    logic          pop;
    logic [DEPTH-1:0] valid;
    logic          match_hit;
    logic [PW-1:0] match_idx;
    logic [AW-1:0] nxt_addr;
    logic [DW-1:0] nxt_data;

    assign full    = (cnt == CW'(DEPTH));
    // No push while full, even on a popping edge, so Stall_M never depends on Mem_Ack.
    assign push    = St_Valid_M & ~full;
    assign pop     = (state == BUSY) & Mem_Ack;
    assign Stall_M = St_Valid_M & full;
    assign Empty   = (cnt == '0);
    assign Count   = cnt;
    assign Mem_Req = (state == BUSY);
    assign nxt_ptr = rd_ptr + PW'(1);

    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = CW'(PW'(PW'(i) - rd_ptr)) < cnt;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop) begin
            cnt_nxt = cnt + CW'(1);
        end else if (pop && !push) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    // With one entry left, the only thing that can follow the popped head is the
    // store being pushed on this same edge, which is not in the arrays yet.
    always_comb begin
        if (cnt == CW'(1)) begin
            nxt_addr = St_Addr_M;
            nxt_data = St_Data_M;
        end else begin
            nxt_addr = addr_q[nxt_ptr];
            nxt_data = data_q[nxt_ptr];
        end
    end

    always_ff @(posedge CLOCK) begin
        if (push) begin
            addr_q[wr_ptr] <= St_Addr_M;
            data_q[wr_ptr] <= St_Data_M;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            cnt      <= '0;
            Mem_Addr <= '0;
            Mem_Data <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= nxt_ptr;
            end
            case (state)
                IDLE: begin
                    if (cnt != '0) begin
                        state    <= BUSY;
                        Mem_Addr <= addr_q[rd_ptr];
                        Mem_Data <= data_q[rd_ptr];
                    end
                end
                BUSY: begin
                    if (Mem_Ack) begin
                        if (cnt_nxt != '0) begin
                            Mem_Addr <= nxt_addr;
                            Mem_Data <= nxt_data;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .PW    (PW)
    ) u_match (
        .valid  (valid),
        .addrs  (addr_q),
        .wr_ptr (wr_ptr),
        .query  (Ld_Addr_M),
        .hit    (match_hit),
        .idx    (match_idx)
    );

    assign Ld_Hit_M  = Ld_Valid_M & match_hit;
    assign Ld_Data_M = Ld_Hit_M ? data_q[match_idx] : '0;

endmodule

// File: tb/tb_store_write_buffer.sv
// Self-checking bench for store_write_buffer: queue-based reference model,
// per-cycle compare, directed scenarios and a random soak.
module tb_store_write_buffer;

    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic          St_Valid_M = 1'b0;
    logic [AW-1:0] St_Addr_M = '0;
    logic [DW-1:0] St_Data_M = '0;
    logic          Ld_Valid_M = 1'b0;
    logic [AW-1:0] Ld_Addr_M = '0;
    logic          Ld_Hit_M;
    logic [DW-1:0] Ld_Data_M;
    logic          Stall_M;
    logic          Mem_Req;
    logic [AW-1:0] Mem_Addr;
    logic [DW-1:0] Mem_Data;
    logic          Mem_Ack = 1'b0;
    logic          Empty;
    logic [2:0]    Count;

    store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .St_Valid_M (St_Valid_M),
        .St_Addr_M  (St_Addr_M),
        .St_Data_M  (St_Data_M),
        .Ld_Valid_M (Ld_Valid_M),
        .Ld_Addr_M  (Ld_Addr_M),
        .Ld_Hit_M   (Ld_Hit_M),
        .Ld_Data_M  (Ld_Data_M),
        .Stall_M    (Stall_M),
        .Mem_Req    (Mem_Req),
        .Mem_Addr   (Mem_Addr),
        .Mem_Data   (Mem_Data),
        .Mem_Ack    (Mem_Ack),
        .Empty      (Empty),
        .Count      (Count)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: the buffer is an ordered list; the drain engine is just
    // "busy or not", and while busy the memory bus shows the oldest entry.
    logic [AW-1:0] mq_addr [$];
    logic [DW-1:0] mq_data [$];
    bit            m_busy = 1'b0;
    int            m_sz;
    bit            m_pop;
    bit            m_push;

    always @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            mq_addr.delete();
            mq_data.delete();
            m_busy = 1'b0;
        end else begin
            m_sz   = mq_addr.size();
            m_pop  = m_busy && Mem_Ack;
            m_push = St_Valid_M && (m_sz < DEPTH);
            if (m_pop) begin
                void'(mq_addr.pop_front());
                void'(mq_data.pop_front());
            end
            if (m_push) begin
                mq_addr.push_back(St_Addr_M);
                mq_data.push_back(St_Data_M);
            end
            if (m_busy) m_busy = !(m_pop && mq_addr.size() == 0);
            else        m_busy = (m_sz > 0);
        end
    end

    // What memory actually receives.
    logic [AW-1:0] log_addr [$];
    logic [DW-1:0] log_data [$];
    always @(posedge CLOCK) begin
        if (!RESET && Mem_Req === 1'b1 && Mem_Ack === 1'b1) begin
            log_addr.push_back(Mem_Addr);
            log_data.push_back(Mem_Data);
        end
    end

    bit            e_hit;
    logic [DW-1:0] e_data;
    always @(negedge CLOCK) begin
        if (!RESET) begin
            e_hit  = 1'b0;
            e_data = '0;
            if (Ld_Valid_M) begin
                for (int i = 0; i < mq_addr.size(); i++) begin
                    if (mq_addr[i] == Ld_Addr_M) begin
                        e_hit  = 1'b1;
                        e_data = mq_data[i];
                    end
                end
            end
            check("cyc_count", Count, mq_addr.size());
            check("cyc_empty", Empty, mq_addr.size() == 0);
            check("cyc_stall", Stall_M, St_Valid_M && mq_addr.size() == DEPTH);
            check("cyc_mem_req", Mem_Req, m_busy);
            if (m_busy && mq_addr.size() > 0) begin
                check("cyc_mem_addr", Mem_Addr, mq_addr[0]);
                check("cyc_mem_data", Mem_Data, mq_data[0]);
            end
            check("cyc_ld_hit", Ld_Hit_M, e_hit);
            check("cyc_ld_data", Ld_Data_M, e_data);
        end
    end

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Present a store and hold it while stalled, as the pipeline would.
    task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit rand_ack);
        bit acc;
        acc = 1'b0;
        St_Valid_M = 1'b1;
        St_Addr_M  = a;
        St_Data_M  = d;
        for (int c = 0; c < 40 && !acc; c++) begin
            acc = (mq_addr.size() < DEPTH);
            if (rand_ack) Mem_Ack = 1'($urandom);
            tick();
        end
        St_Valid_M = 1'b0;
        check("store_accepted", acc, 1'b1);
    endtask

    task automatic drain(input bit rand_ack);
        int c;
        c = 0;
        St_Valid_M = 1'b0;
        while (mq_addr.size() > 0 && c < 100) begin
            Mem_Ack = rand_ack ? 1'($urandom) : 1'b1;
            tick();
            c++;
        end
        Mem_Ack = 1'b0;
        check("drain_empty", Empty, 1'b1);
        check("drain_req_low", Mem_Req, 1'b0);
    endtask

    logic [DW-1:0] wdat [10];
    int base;

    initial begin
        // reset values, asynchronous
        #1 RESET = 1'b1;
        #1;
        check("rst_count", Count, 0);
        check("rst_empty", Empty, 1);
        check("rst_mem_req", Mem_Req, 0);
        check("rst_mem_addr", Mem_Addr, 0);
        check("rst_mem_data", Mem_Data, 0);
        check("rst_ld_hit", Ld_Hit_M, 0);
        check("rst_ld_data", Ld_Data_M, 0);
        check("rst_stall", Stall_M, 0);
        tick();
        tick();
        #2 RESET = 1'b0;
        tick();

        // single store, ack tied high
        Mem_Ack = 1'b1;
        base = log_addr.size();
        St_Valid_M = 1'b1; St_Addr_M = 32'h10; St_Data_M = 32'hDEADBEEF;
        tick();
        St_Valid_M = 1'b0;
        check("single_req_n", Mem_Req, 0);
        tick();
        check("single_req_n1", Mem_Req, 1);
        check("single_addr", Mem_Addr, 32'h10);
        check("single_data", Mem_Data, 32'hDEADBEEF);
        tick();
        check("single_req_n2", Mem_Req, 0);
        check("single_empty", Empty, 1);
        check("single_writes", log_addr.size() - base, 1);
        Mem_Ack = 1'b0;
        tick();

        // fill and stall
        base = log_addr.size();
        for (int i = 0; i < 4; i++) store(32'h100 + i, $urandom, 1'b0);
        check("fill_count", Count, 4);
        St_Valid_M = 1'b1; St_Addr_M = 32'h104; St_Data_M = 32'h5A5A0104;
        #1;
        check("fill_stall", Stall_M, 1);
        tick();
        check("fill_stall_hold", Stall_M, 1);
        check("fill_count_hold", Count, 4);
        Mem_Ack = 1'b1;
        store(32'h104, 32'h5A5A0104, 1'b0);
        drain(1'b0);
        check("fill_writes", log_addr.size() - base, 5);
        for (int i = 0; i < 5; i++) begin
            if (base + i < log_addr.size()) check("fill_order", log_addr[base + i], 32'h100 + i);
        end
        if (base + 4 < log_data.size()) check("fill_fifth_data", log_data[base + 4], 32'h5A5A0104);

        // forwarding priority
        store(32'h20, 32'd1, 1'b0);
        store(32'h20, 32'd2, 1'b0);
        Ld_Valid_M = 1'b1; Ld_Addr_M = 32'h20;
        #1;
        check("fwd_hit", Ld_Hit_M, 1);
        check("fwd_data", Ld_Data_M, 2);
        Ld_Addr_M = 32'h24;
        #1;
        check("fwd_miss_hit", Ld_Hit_M, 0);
        check("fwd_miss_data", Ld_Data_M, 0);
        tick();
        Ld_Addr_M = 32'h20;
        St_Valid_M = 1'b1; St_Addr_M = 32'h20; St_Data_M = 32'd3;
        #1;
        check("fwd_excl_incoming", Ld_Data_M, 2);
        tick();
        St_Valid_M = 1'b0;
        #1;
        check("fwd_new_youngest", Ld_Data_M, 3);
        Ld_Valid_M = 1'b0;
        #1;
        check("fwd_needs_valid", Ld_Hit_M, 0);
        drain(1'b0);

        // simultaneous push and pop
        store(32'h40, 32'hA0, 1'b0);
        store(32'h41, 32'hA1, 1'b0);
        check("sim_count", Count, 2);
        check("sim_req", Mem_Req, 1);
        check("sim_head", Mem_Addr, 32'h40);
        St_Valid_M = 1'b1; St_Addr_M = 32'h42; St_Data_M = 32'hA2;
        Mem_Ack = 1'b1;
        tick();
        St_Valid_M = 1'b0;
        Mem_Ack = 1'b0;
        check("sim_count_same", Count, 2);
        check("sim_next_head", Mem_Addr, 32'h41);
        drain(1'b0);

        // wrap-around with random ack
        base = log_addr.size();
        for (int i = 0; i < 10; i++) begin
            wdat[i] = $urandom;
            store(i, wdat[i], 1'b1);
        end
        drain(1'b1);
        check("wrap_writes", log_addr.size() - base, 10);
        for (int i = 0; i < 10; i++) begin
            if (base + i < log_addr.size()) begin
                check("wrap_addr", log_addr[base + i], i);
                check("wrap_data", log_data[base + i], wdat[i]);
            end
        end

        // reset mid-drain
        store(32'h70, 32'h1, 1'b0);
        store(32'h71, 32'h2, 1'b0);
        store(32'h72, 32'h3, 1'b0);
        check("rstd_req", Mem_Req, 1);
        check("rstd_count", Count, 3);
        #1 RESET = 1'b1;
        #1;
        check("rstd_req_now", Mem_Req, 0);
        check("rstd_count_now", Count, 0);
        check("rstd_empty_now", Empty, 1);
        base = log_addr.size();
        tick();
        #2 RESET = 1'b0;
        Mem_Ack = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("rstd_no_write", log_addr.size() - base, 0);
        check("rstd_req_after", Mem_Req, 0);
        Mem_Ack = 1'b0;

        // random soak against the model
        for (int i = 0; i < 400; i++) begin
            St_Valid_M = 1'($urandom);
            St_Addr_M  = $urandom_range(0, 7);
            St_Data_M  = $urandom;
            Ld_Valid_M = 1'($urandom);
            Ld_Addr_M  = $urandom_range(0, 7);
            Mem_Ack    = ($urandom_range(0, 3) != 0);
            tick();
        end
        Ld_Valid_M = 1'b0;
        drain(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
